// File: rtl/tagged_fifo_pkg.sv
// Shared definitions for the tagged-record FIFO: default field sizes, the
// legacy fixed-width record layout, and small helpers for building records,
// printing them and sizing pointers.
package tagged_fifo_pkg;

    localparam int TAG_W_DEF  = 8;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    // Default record layout, field order {valid, tag, data}.
    typedef struct packed {
        logic                  valid;
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] data;
    } tagged_rec_t;

    function automatic tagged_rec_t make_rec(
        input logic                  valid,
        input logic [TAG_W_DEF-1:0]  tag,
        input logic [DATA_W_DEF-1:0] data
    );
        tagged_rec_t rec;
        rec.valid = valid;
        rec.tag   = tag;
        rec.data  = data;
        return rec;
    endfunction

    // Human-readable form of a record, for use in log messages.
    function automatic string rec_to_string(input tagged_rec_t rec);
        return $sformatf("Valid=%0h tag=%02h data=%08h", rec.valid, rec.tag, rec.data);
    endfunction

    // Pointer width for a DEPTH-entry store; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tagged_fifo_ptr.sv
// Wrap-around index for a DEPTH-entry store: advances on inc_i, returns to 0
// after DEPTH-1 (DEPTH need not be a power of two), and clears on clr_i.
module tagged_fifo_ptr
    import tagged_fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next index: clear wins over advance; explicit wrap at the last entry.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            if (ptr_q == PTR_W'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Index register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/tagged_fifo.sv
// Elastic buffer of tagged records with valid/ready on both sides,
// first-word fall-through head, a single-tag drop filter, synchronous flush,
// and a saturating count of filtered records.
module tagged_fifo
    import tagged_fifo_pkg::*;
#(
    parameter int TAG_W      = TAG_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DROP_CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TAG_W-1:0]           out_tag,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       flush,
    input  logic                       drop_en,
    input  logic [TAG_W-1:0]           drop_tag,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic [DROP_CNT_W-1:0]      drop_cnt
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Valid is implied by occupancy, so only tag and data are stored.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic [DROP_CNT_W-1:0] drop_cnt_d;

    logic push;
    logic drop_hit;
    logic store;
    logic pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full && !rst;
    assign out_valid = !empty;

    // A push into a flush cycle is acknowledged but neither stored nor
    // counted as filtered; a pop in a flush cycle has no effect either.
    assign push     = in_valid && in_ready;
    assign drop_hit = push && drop_en && (in_tag == drop_tag);
    assign store    = push && !drop_hit && !flush;
    assign pop      = out_valid && out_ready && !flush;

    tagged_fifo_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (store),
        .clr_i (flush),
        .ptr_o (wr_ptr)
    );

    tagged_fifo_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (pop),
        .clr_i (flush),
        .ptr_o (rd_ptr)
    );

    // Occupancy and filter-count next state; flush empties but keeps drop_cnt.
    always_comb begin
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            count_d = '0;
        end else begin
            if (store && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !store) begin
                count_d = count_q - 1'b1;
            end
            if (drop_hit && (drop_cnt_q != '1)) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    // Occupancy and filter-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (store) begin
            mem_q[wr_ptr] <= '{tag: in_tag, data: in_data};
        end
    end

    assign out_tag  = mem_q[rd_ptr].tag;
    assign out_data = mem_q[rd_ptr].data;
    assign count    = count_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_tagged_fifo.sv
// Bench for tagged_fifo: two instances (DEPTH=4 with a 16-bit drop counter,
// DEPTH=3 with a 2-bit drop counter) share one stimulus stream. A queue
// model per instance is compared every cycle; directed phases add literal
// expectations.
module tb_tagged_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_tag;
    logic [31:0] in_data;
    logic        out_ready;
    logic        flush;
    logic        drop_en;
    logic [7:0]  drop_tag;

    logic        a_in_ready, a_out_valid, a_full, a_empty;
    logic [7:0]  a_out_tag;
    logic [31:0] a_out_data;
    logic [2:0]  a_count;
    logic [15:0] a_drop_cnt;

    logic        b_in_ready, b_out_valid, b_full, b_empty;
    logic [7:0]  b_out_tag;
    logic [31:0] b_out_data;
    logic [1:0]  b_count;
    logic [1:0]  b_drop_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tagged_fifo #(.TAG_W(8), .DATA_W(32), .DEPTH(4), .DROP_CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_tag(in_tag), .in_data(in_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_tag(a_out_tag), .out_data(a_out_data),
        .flush(flush), .drop_en(drop_en), .drop_tag(drop_tag),
        .count(a_count), .full(a_full), .empty(a_empty), .drop_cnt(a_drop_cnt)
    );

    tagged_fifo #(.TAG_W(8), .DATA_W(32), .DEPTH(3), .DROP_CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_tag(in_tag), .in_data(in_data), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_tag(b_out_tag), .out_data(b_out_data),
        .flush(flush), .drop_en(drop_en), .drop_tag(drop_tag),
        .count(b_count), .full(b_full), .empty(b_empty), .drop_cnt(b_drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: one queue per instance ----------------
    logic [39:0] qa[$];
    logic [39:0] qb[$];
    int          dca, dcb;
    bit          pa, pb;

    always @(posedge clk) begin
        if (rst) begin
            qa.delete(); qb.delete(); dca = 0; dcb = 0;
        end else if (flush) begin
            qa.delete(); qb.delete();
        end else begin
            pa = in_valid && (qa.size() < 4);
            pb = in_valid && (qb.size() < 3);
            if (out_ready && qa.size() > 0) void'(qa.pop_front());
            if (out_ready && qb.size() > 0) void'(qb.pop_front());
            if (pa) begin
                if (drop_en && in_tag == drop_tag) dca = (dca < 65535) ? dca + 1 : dca;
                else qa.push_back({in_tag, in_data});
            end
            if (pb) begin
                if (drop_en && in_tag == drop_tag) dcb = (dcb < 3) ? dcb + 1 : dcb;
                else qb.push_back({in_tag, in_data});
            end
        end
    end

    task automatic check_dut(input string n, input logic ir, input logic ov, input logic fu,
                             input logic em, input int cnt, input int dc, input logic [39:0] head,
                             input int depth, input int msize, input logic [39:0] mhead, input int mdc);
        chk({n, "_in_ready"}, ir, !rst && (msize < depth));
        chk({n, "_out_valid"}, ov, msize > 0);
        chk({n, "_full"}, fu, msize == depth);
        chk({n, "_empty"}, em, msize == 0);
        chk({n, "_count"}, cnt, msize);
        chk({n, "_drop_cnt"}, dc, mdc);
        if (msize > 0) chk({n, "_head"}, head, mhead);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check_dut("a", a_in_ready, a_out_valid, a_full, a_empty, int'(a_count), int'(a_drop_cnt),
                      {a_out_tag, a_out_data}, 4, qa.size(), (qa.size() > 0) ? qa[0] : 40'h0, dca);
            check_dut("b", b_in_ready, b_out_valid, b_full, b_empty, int'(b_count), int'(b_drop_cnt),
                      {b_out_tag, b_out_data}, 3, qb.size(), (qb.size() > 0) ? qb[0] : 40'h0, dcb);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push1(input logic [7:0] t, input logic [31:0] d);
        in_valid = 1'b1; in_tag = t; in_data = d;
        cyc();
        in_valid = 1'b0;
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    int idx, nrecv, budget;
    bit acc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_tag = '0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; drop_en = 1'b0; drop_tag = '0;

        // reset then idle
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_empty", a_empty, 1'b1);
        chk("rst_full", a_full, 1'b0);
        chk("rst_count", a_count, 3'd0);
        chk("rst_drop_cnt", a_drop_cnt, 16'd0);
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_tag", a_out_tag, 8'h00);
        chk("rst_out_data", a_out_data, 32'h0);

        // fill A to DEPTH=4 with the consumer stalled
        for (int i = 0; i < 4; i++) push1(8'(i + 1), 32'hA0 + 32'(i));
        #1;
        chk("fill_full", a_full, 1'b1);
        chk("fill_in_ready", a_in_ready, 1'b0);
        chk("fill_count", a_count, 3'd4);
        chk("fill_head_tag", a_out_tag, 8'h01);
        chk("b_fill_count", b_count, 2'd3);

        // drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_tag", a_out_tag, 8'(i + 1));
            chk("drain_data", a_out_data, 32'hA0 + 32'(i));
            cyc();
        end
        out_ready = 1'b0;
        #1;
        chk("drain_empty", a_empty, 1'b1);

        // concurrent push and pop at count=2
        push1(8'h20, 32'hC0);
        push1(8'h21, 32'hC1);
        in_valid = 1'b1; in_tag = 8'h10; in_data = 32'hD0; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("pp_count", a_count, 3'd2);
        chk("pp_head_tag", a_out_tag, 8'h21);
        out_ready = 1'b1; cyc(); cyc(); out_ready = 1'b0;

        // tag filter
        drop_en = 1'b1; drop_tag = 8'h55;
        push1(8'h55, 32'hE0);
        push1(8'h56, 32'hE1);
        push1(8'h55, 32'hE2);
        #1;
        chk("flt_count", a_count, 3'd1);
        chk("flt_drop_cnt", a_drop_cnt, 16'd2);
        chk("flt_head_tag", a_out_tag, 8'h56);
        chk("b_flt_drop_cnt", b_drop_cnt, 2'd2);
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push1(8'h55, 32'hE8);
        #1;
        chk("sat_b_drop_cnt", b_drop_cnt, 2'd3);
        chk("sat_a_drop_cnt", a_drop_cnt, 16'd8);
        chk("sat_a_count", a_count, 3'd0);
        drop_en = 1'b0;

        // flush with a simultaneous push and pop
        push1(8'h31, 32'hF1);
        push1(8'h32, 32'hF2);
        push1(8'h33, 32'hF3);
        #1;
        chk("pre_flush_count", a_count, 3'd3);
        flush = 1'b1; in_valid = 1'b1; in_tag = 8'h77; in_data = 32'h77; out_ready = 1'b1;
        #1;
        chk("flush_in_ready", a_in_ready, 1'b1);
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("flush_count", a_count, 3'd0);
        chk("flush_empty", a_empty, 1'b1);
        chk("flush_drop_cnt", a_drop_cnt, 16'd8);

        // reset mid-operation with in_valid held through it
        push1(8'h41, 32'h41);
        push1(8'h42, 32'h42);
        rst = 1'b1; in_valid = 1'b1; in_tag = 8'h88; in_data = 32'h88;
        #1;
        chk("mrst_in_ready", a_in_ready, 1'b0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_count", a_count, 3'd0);
        chk("mrst_in_ready_rel", a_in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("mrst_push_count", a_count, 3'd1);
        chk("mrst_head_tag", a_out_tag, 8'h88);
        chk("mrst_drop_cnt", a_drop_cnt, 16'd0);
        out_ready = 1'b1; cyc(); out_ready = 1'b0;

        // DEPTH=3 wrap: 10 records, random consumer, no producer gaps
        idx = 0; nrecv = 0; budget = 0;
        while (nrecv < 10 && budget < 300) begin
            in_valid  = (idx < 10);
            in_tag    = 8'h60 + 8'(idx);
            in_data   = 32'hB000 + 32'(idx);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_valid && b_in_ready;
            if (b_out_valid && out_ready) begin
                chk("wrap_order", b_out_tag, 8'h60 + 8'(nrecv));
                nrecv++;
            end
            chk("wrap_count_le3", b_count <= 2'd3 && !(b_count == 2'd3 && !b_full), 1'b1);
            cyc();
            if (acc) idx++;
            budget++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("wrap_received", nrecv, 10);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
